// File: rtl/armedf_pkg.sv
// Package: armedf_pkg
// Shared FSM state encodings, parameter defaults and the wait-counter width
// used by the M68K bus responder and its wait counter.
package armedf_pkg;

   // Width of the shared wait / timeout counter
   localparam int WAIT_CNT_W = 8;

   // Default wait (BRAM/IO) and timeout lengths in clk_sys cycles
   localparam int BRAM_WAIT_DEF = 2;
   localparam int TIMEOUT_DEF   = 255;

   // Bus-cycle FSM states, 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_ROM_REQ  = 3'd1,
      ST_ROM_WAIT = 3'd2,
      ST_WAIT     = 3'd3,
      ST_ACK      = 3'd4,
      ST_ERR      = 3'd5,
      ST_END      = 3'd6
   } state_t;

   // A cycle that is paced by the fixed BRAM wait: a ROM write, or any
   // RAM/palette/IO select when the ROM is not selected.
   function automatic logic is_bram_class(input logic rom_cs,
                                          input logic rw,
                                          input logic bram_cs,
                                          input logic io_cs);
      return (rom_cs && !rw) || (!rom_cs && (bram_cs || io_cs));
   endfunction

endpackage

// File: rtl/m68k_wait_ctr.sv
// Module: m68k_wait_ctr
// Loadable saturating down/up counter. Counting down paces the fixed BRAM
// wait (zero flag); counting up measures elapsed cycles for the timeout
// (timeout flag). It never wraps in either direction.
module m68k_wait_ctr
   import armedf_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
)
(
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  load,
   input  logic [WAIT_CNT_W-1:0] load_val,
   input  logic                  inc,
   input  logic                  dec,
   output logic                  zero,
   output logic                  timeout
);

   localparam logic [WAIT_CNT_W-1:0] TMO_VAL = WAIT_CNT_W'(TIMEOUT);
   localparam logic [WAIT_CNT_W-1:0] CNT_MAX = '1;

   logic [WAIT_CNT_W-1:0] cnt_q;
   logic [WAIT_CNT_W-1:0] cnt_d;

   // Next count: load wins, otherwise saturating increment or decrement
   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (inc && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + WAIT_CNT_W'(1);
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - WAIT_CNT_W'(1);
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero    = (cnt_q == '0);
   assign timeout = (cnt_q >= TMO_VAL);

endmodule

// File: rtl/m68k_bus_responder.sv
// Module: m68k_bus_responder
// Terminates every classified 68000 bus cycle exactly once. BRAM/IO targets
// get DTACK after a fixed wait, program-ROM reads wait for the SDRAM
// handshake, unmapped cycles fall back after a timeout.
// Optional feature macro: M68K_BERR_EN (timeout terminates with BERR
// instead of DTACK).
module m68k_bus_responder
   import armedf_pkg::*;
#(
   parameter int BRAM_WAIT = BRAM_WAIT_DEF,
   parameter int TIMEOUT   = TIMEOUT_DEF
)
(
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        m68k_as_n,
   input  logic        m68k_rw,
   input  logic [22:0] m68k_a,
   input  logic        rom_cs,
   input  logic        bram_cs,
   input  logic        io_cs,
   input  logic        rom_valid,
   output logic        rom_req,
   output logic [22:0] rom_addr,
   output logic        m68k_dtack_n,
   output logic        m68k_berr_n,
   output logic        busy
);

`ifdef M68K_BERR_EN
   localparam state_t FALLBACK_ST = ST_ERR;
`else
   localparam state_t FALLBACK_ST = ST_ACK;
`endif

   localparam logic [WAIT_CNT_W-1:0] BRAM_LOAD = WAIT_CNT_W'(BRAM_WAIT - 1);
   localparam logic [WAIT_CNT_W-1:0] CNT_ONE   = WAIT_CNT_W'(1);

   state_t      state_q, state_d;
   logic        unmapped_q, unmapped_d;
   logic [22:0] rom_addr_q, rom_addr_d;
   logic        rom_req_q, rom_req_d;
   logic        dtack_n_q, dtack_n_d;
   logic        busy_q, busy_d;

   logic                  ctr_load;
   logic [WAIT_CNT_W-1:0] ctr_load_val;
   logic                  ctr_inc;
   logic                  ctr_dec;
   logic                  ctr_zero;
   logic                  ctr_tmo;

   m68k_wait_ctr #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_ctr (
      .clk_sys  (clk_sys),
      .reset    (reset),
      .load     (ctr_load),
      .load_val (ctr_load_val),
      .inc      (ctr_inc),
      .dec      (ctr_dec),
      .zero     (ctr_zero),
      .timeout  (ctr_tmo)
   );

   // Next state, counter control and next values of the registered outputs
   always_comb begin
      state_d      = state_q;
      unmapped_d   = unmapped_q;
      rom_addr_d   = rom_addr_q;
      ctr_load     = 1'b0;
      ctr_load_val = '0;
      ctr_inc      = 1'b0;
      ctr_dec      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            ctr_load = 1'b1;
            if (!m68k_as_n) begin
               unmapped_d = 1'b0;
               if (rom_cs && m68k_rw) begin
                  state_d      = ST_ROM_REQ;
                  rom_addr_d   = m68k_a;
                  ctr_load_val = CNT_ONE;
               end else if (is_bram_class(rom_cs, m68k_rw, bram_cs, io_cs)) begin
                  state_d      = ST_WAIT;
                  ctr_load_val = BRAM_LOAD;
               end else begin
                  state_d      = ST_WAIT;
                  unmapped_d   = 1'b1;
                  ctr_load_val = CNT_ONE;
               end
            end
         end
         ST_ROM_REQ: begin
            ctr_inc = 1'b1;
            state_d = m68k_as_n ? ST_END : ST_ROM_WAIT;
         end
         ST_ROM_WAIT: begin
            ctr_inc = 1'b1;
            if (m68k_as_n) begin
               state_d = ST_END;
            end else if (rom_valid) begin
               state_d = ST_ACK;
            end else if (ctr_tmo) begin
               state_d = FALLBACK_ST;
            end
         end
         ST_WAIT: begin
            if (m68k_as_n) begin
               state_d = ST_END;
            end else if (unmapped_q) begin
               ctr_inc = 1'b1;
               if (ctr_tmo) begin
                  state_d = FALLBACK_ST;
               end
            end else begin
               ctr_dec = 1'b1;
               if (ctr_zero) begin
                  state_d = ST_ACK;
               end
            end
         end
         ST_ACK: begin
            if (m68k_as_n) begin
               state_d = ST_END;
            end
         end
         ST_ERR: begin
            if (m68k_as_n) begin
               state_d = ST_END;
            end
         end
         ST_END: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      rom_req_d = (state_d == ST_ROM_REQ);
      dtack_n_d = (state_d != ST_ACK);
      busy_d    = (state_d != ST_IDLE);
   end

   // State and output registers; reset forces IDLE regardless of the bus
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         unmapped_q <= 1'b0;
         rom_addr_q <= '0;
         rom_req_q  <= 1'b0;
         dtack_n_q  <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         unmapped_q <= unmapped_d;
         rom_addr_q <= rom_addr_d;
         rom_req_q  <= rom_req_d;
         dtack_n_q  <= dtack_n_d;
         busy_q     <= busy_d;
      end
   end

`ifdef M68K_BERR_EN
   logic berr_n_q;

   // Bus-error register, low only while the FSM sits in ERR
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         berr_n_q <= 1'b1;
      end else begin
         berr_n_q <= (state_d != ST_ERR);
      end
   end

   assign m68k_berr_n = berr_n_q;
`else
   assign m68k_berr_n = 1'b1;
`endif

   assign rom_req      = rom_req_q;
   assign rom_addr     = rom_addr_q;
   assign m68k_dtack_n = dtack_n_q;
   assign busy         = busy_q;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Testbench: tb_m68k_bus_responder
// Randomised and directed bus cycles against a timeline model of the
// responder: each cycle's termination edge is computed from its class and
// the planned SDRAM/abort timing, then every output is compared per edge.
module tb_m68k_bus_responder;

   localparam int BW  = 2;
   localparam int TMO = 16;

   localparam int C_ROMRD = 0;
   localparam int C_ROMWR = 1;
   localparam int C_BRAM  = 2;
   localparam int C_IO    = 3;
   localparam int C_NONE  = 4;

`ifdef M68K_BERR_EN
   localparam bit BERR_EN = 1'b1;
`else
   localparam bit BERR_EN = 1'b0;
`endif

   logic        clk_sys   = 1'b0;
   logic        reset     = 1'b1;
   logic        m68k_as_n = 1'b1;
   logic        m68k_rw   = 1'b1;
   logic [22:0] m68k_a    = '0;
   logic        rom_cs    = 1'b0;
   logic        bram_cs   = 1'b0;
   logic        io_cs     = 1'b0;
   logic        rom_valid = 1'b0;
   logic        rom_req;
   logic [22:0] rom_addr;
   logic        m68k_dtack_n;
   logic        m68k_berr_n;
   logic        busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk_sys = ~clk_sys;

   m68k_bus_responder #(
      .BRAM_WAIT (BW),
      .TIMEOUT   (TMO)
   ) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .m68k_as_n    (m68k_as_n),
      .m68k_rw      (m68k_rw),
      .m68k_a       (m68k_a),
      .rom_cs       (rom_cs),
      .bram_cs      (bram_cs),
      .io_cs        (io_cs),
      .rom_valid    (rom_valid),
      .rom_req      (rom_req),
      .rom_addr     (rom_addr),
      .m68k_dtack_n (m68k_dtack_n),
      .m68k_berr_n  (m68k_berr_n),
      .busy         (busy)
   );

   // One whole bus cycle. Edge 0 is the start edge. v = edge at which
   // rom_valid is sampled (-1 none), hold = extra cycles AS stays low after
   // the acknowledge, a = edge at which AS is sampled high early (0 none),
   // b2b = drive AS low again during the END cycle for the next call.
   task automatic run_txn(input int cls, input logic [22:0] addr, input int v,
                          input int hold, input int a, input bit b2b,
                          input string name);
      int ack, rel, last, tmo_edge;
      bit fallback, aborted;
      bit exp_dtack, exp_berr, exp_busy, exp_req;

      fallback = 1'b0;
      case (cls)
         C_ROMRD: begin
            tmo_edge = (TMO < 2) ? 2 : TMO;
            if (v >= 2 && v <= tmo_edge) begin
               ack = v;
            end else begin
               ack      = tmo_edge;
               fallback = 1'b1;
            end
         end
         C_NONE: begin
            ack      = TMO;
            fallback = 1'b1;
         end
         default: ack = BW;
      endcase
      aborted = (a >= 1) && (a <= ack);
      rel     = aborted ? a : ack + 1 + hold;
      last    = rel + 1;
      if (!b2b && (v + 1 > last)) last = v + 1;

      m68k_as_n = 1'b0;
      m68k_a    = addr;
      rom_valid = (v == 0);
      case (cls)
         C_ROMRD: begin
            m68k_rw = 1'b1; rom_cs = 1'b1;
            bram_cs = 1'($urandom_range(1)); io_cs = 1'($urandom_range(1));
         end
         C_ROMWR: begin
            m68k_rw = 1'b0; rom_cs = 1'b1;
            bram_cs = 1'($urandom_range(1)); io_cs = 1'($urandom_range(1));
         end
         C_BRAM: begin
            m68k_rw = 1'($urandom_range(1)); rom_cs = 1'b0;
            bram_cs = 1'b1; io_cs = 1'($urandom_range(1));
         end
         C_IO: begin
            m68k_rw = 1'($urandom_range(1)); rom_cs = 1'b0;
            bram_cs = 1'b0; io_cs = 1'b1;
         end
         default: begin
            m68k_rw = 1'($urandom_range(1)); rom_cs = 1'b0;
            bram_cs = 1'b0; io_cs = 1'b0;
         end
      endcase

      for (int k = 0; k <= last; k++) begin
         @(posedge clk_sys);
         #1;
         exp_dtack = !(!aborted && !(fallback && BERR_EN) && k >= ack && k < rel);
         exp_berr  = !(!aborted && fallback && BERR_EN && k >= ack && k < rel);
         exp_busy  = (k <= rel);
         exp_req   = (cls == C_ROMRD) && (k == 0);
         checks += 4;
         if (m68k_dtack_n !== exp_dtack) begin
            failures++;
            $display("[TB] FAIL %s edge=%0d dtack_n actual=%b expected=%b", name, k, m68k_dtack_n, exp_dtack);
         end
         if (m68k_berr_n !== exp_berr) begin
            failures++;
            $display("[TB] FAIL %s edge=%0d berr_n actual=%b expected=%b", name, k, m68k_berr_n, exp_berr);
         end
         if (busy !== exp_busy) begin
            failures++;
            $display("[TB] FAIL %s edge=%0d busy actual=%b expected=%b", name, k, busy, exp_busy);
         end
         if (rom_req !== exp_req) begin
            failures++;
            $display("[TB] FAIL %s edge=%0d rom_req actual=%b expected=%b", name, k, rom_req, exp_req);
         end
         if (cls == C_ROMRD && k == 0) begin
            checks++;
            if (rom_addr !== addr) begin
               failures++;
               $display("[TB] FAIL %s rom_addr actual=%h expected=%h", name, rom_addr, addr);
            end
         end
         m68k_as_n = !((k + 1 < rel) || (b2b && (k + 1 == rel + 1)));
         rom_valid = (k + 1 == v);
         if (!b2b && (k + 1 >= rel)) begin
            rom_cs = 1'b0; bram_cs = 1'b0; io_cs = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(posedge clk_sys);
      #1;
      checks += 5;
      if (m68k_dtack_n !== 1'b1) begin failures++; $display("[TB] FAIL reset dtack_n actual=%b expected=1", m68k_dtack_n); end
      if (m68k_berr_n !== 1'b1)  begin failures++; $display("[TB] FAIL reset berr_n actual=%b expected=1", m68k_berr_n); end
      if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL reset busy actual=%b expected=0", busy); end
      if (rom_req !== 1'b0)      begin failures++; $display("[TB] FAIL reset rom_req actual=%b expected=0", rom_req); end
      if (rom_addr !== 23'd0)    begin failures++; $display("[TB] FAIL reset rom_addr actual=%h expected=0", rom_addr); end
      reset = 1'b0;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic test_bram_read();
      run_txn(C_BRAM, 23'h000100, -1, 0, 0, 1'b0, "bram_read");
      run_txn(C_BRAM, 23'h000200, -1, 3, 0, 1'b0, "bram_read_hold");
      run_txn(C_ROMWR, 23'h0000aa, 4, 1, 0, 1'b0, "rom_write_as_bram");
   endtask

   task automatic test_rom_read();
      run_txn(C_ROMRD, 23'h012345, 7, 0, 0, 1'b0, "rom_read");
      run_txn(C_ROMRD, 23'h7fffff, 2, 1, 0, 1'b0, "rom_read_fast");
      run_txn(C_ROMRD, 23'h055555, TMO, 0, 0, 1'b0, "rom_read_at_timeout");
      run_txn(C_ROMRD, 23'h02aaaa, -1, 0, 0, 1'b0, "rom_read_timeout");
   endtask

   task automatic test_abort();
      run_txn(C_ROMRD, 23'h012345, 6, 0, 3, 1'b0, "abort_rom_stray_valid");
      run_txn(C_ROMRD, 23'h000777, 5, 0, 1, 1'b0, "abort_rom_in_req");
      run_txn(C_BRAM, 23'h000010, -1, 0, BW, 1'b0, "abort_bram");
   endtask

   task automatic test_unmapped();
      run_txn(C_NONE, 23'h400000, -1, 0, 0, 1'b0, "unmapped");
      run_txn(C_NONE, 23'h400002, 5, 2, 0, 1'b0, "unmapped_stray_valid");
   endtask

   task automatic test_back_to_back();
      run_txn(C_IO, 23'h300000, -1, 0, 0, 1'b1, "b2b_io");
      run_txn(C_BRAM, 23'h100000, -1, 0, 0, 1'b0, "b2b_bram");
   endtask

   task automatic test_reset_mid_cycle();
      logic [22:0] addr;
      m68k_as_n = 1'b0; bram_cs = 1'b1; m68k_rw = 1'b1;
      @(posedge clk_sys); #1;
      checks++;
      if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait start busy actual=%b expected=1", busy); end
      reset = 1'b1;
      @(posedge clk_sys); #1;
      checks += 4;
      if (m68k_dtack_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait dtack_n actual=%b expected=1", m68k_dtack_n); end
      if (m68k_berr_n !== 1'b1)  begin failures++; $display("[TB] FAIL rst_wait berr_n actual=%b expected=1", m68k_berr_n); end
      if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL rst_wait busy actual=%b expected=0", busy); end
      if (rom_req !== 1'b0)      begin failures++; $display("[TB] FAIL rst_wait rom_req actual=%b expected=0", rom_req); end
      reset = 1'b0; m68k_as_n = 1'b1; bram_cs = 1'b0;
      @(posedge clk_sys); #1;

      addr = 23'($urandom());
      if (addr == 23'd0) addr = 23'h1;
      m68k_as_n = 1'b0; rom_cs = 1'b1; m68k_a = addr;
      @(posedge clk_sys); #1;
      @(posedge clk_sys); #1;
      rom_valid = 1'b1;
      @(posedge clk_sys); #1;
      rom_valid = 1'b0;
      checks++;
      if (m68k_dtack_n !== 1'b0) begin failures++; $display("[TB] FAIL rst_ack pre dtack_n actual=%b expected=0", m68k_dtack_n); end
      reset = 1'b1;
      @(posedge clk_sys); #1;
      checks += 3;
      if (m68k_dtack_n !== 1'b1) begin failures++; $display("[TB] FAIL rst_ack dtack_n actual=%b expected=1", m68k_dtack_n); end
      if (busy !== 1'b0)         begin failures++; $display("[TB] FAIL rst_ack busy actual=%b expected=0", busy); end
      if (rom_addr !== 23'd0)    begin failures++; $display("[TB] FAIL rst_ack rom_addr actual=%h expected=0", rom_addr); end
      reset = 1'b0; m68k_as_n = 1'b1; rom_cs = 1'b0;
      @(posedge clk_sys); #1;
   endtask

   task automatic test_random();
      int cls, v, hold, a;
      bit b2b;
      for (int n = 0; n < 40; n++) begin
         cls  = $urandom_range(4);
         hold = $urandom_range(3);
         b2b  = 1'($urandom_range(1));
         a    = ($urandom_range(4) == 0) ? $urandom_range(18, 1) : 0;
         if (cls == C_ROMRD) begin
            v = ($urandom_range(7) == 0) ? -1 : $urandom_range(12, 2);
         end else begin
            v = ($urandom_range(3) == 0) ? $urandom_range(8, 1) : -1;
         end
         run_txn(cls, 23'($urandom()), v, hold, a, b2b, $sformatf("rand%0d_c%0d", n, cls));
      end
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      test_reset();
      test_bram_read();
      test_rom_read();
      test_abort();
      test_unmapped();
      test_back_to_back();
      test_reset_mid_cycle();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
